pcpi_result_tx: RTL and testbench

PCPI_RESULT_TX -- requirements
Module: pcpi_result_tx

---
 rtl/pcpi_result_tx.sv | 121 ++++++++++++
 tb/tb_pcpi_result_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_result_tx.sv
// Serialises a PCPI result word into 4-bit nibbles, least-significant first,
// using a four-phase handshake against an asynchronous host ack pin.
module pcpi_result_tx #(
  parameter int NIBBLES     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 res_valid,
  input  logic [4*NIBBLES-1:0] res_data,
  output logic                 res_ready,
  input  logic                 ack,
  output logic [3:0]           nib_out,
  output logic                 nib_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    PRESENT,
    RELEASE
  } state_t;

  state_t             state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic               ack_s;
  logic [W-1:0]       shift;
  logic [W-1:0]       next_shift;
  logic [IDX_W-1:0]   index;

  // Only the last synchronizer flop may influence state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
    end
  end

  assign ack_s      = ack_sync[SYNC_STAGES-1];
  assign next_shift = shift >> 4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= '0;
      index     <= '0;
      nib_out   <= 4'h0;
      nib_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          index <= '0;
          if (res_valid && res_ready) begin
            shift     <= res_data;
            state     <= ARM;
            res_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            res_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        // A stale high ack from the previous word must drop before presenting.
        ARM: begin
          if (!ack_s) begin
            state     <= PRESENT;
            nib_valid <= 1'b1;
            nib_out   <= shift[3:0];
          end
        end

        PRESENT: begin
          if (ack_s) begin
            state     <= RELEASE;
            nib_valid <= 1'b0;
          end
        end

        RELEASE: begin
          if (!ack_s) begin
            if (index < LAST_IDX) begin
              shift     <= next_shift;
              index     <= index + IDX_W'(1);
              nib_out   <= next_shift[3:0];
              nib_valid <= 1'b1;
              state     <= PRESENT;
            end else begin
              state     <= IDLE;
              index     <= '0;
              done      <= 1'b1;
              busy      <= 1'b0;
              res_ready <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Invariants the host relies on: bounded index, nibble stable while valid.
  assert property (@(posedge clk) disable iff (!rst_n) index <= LAST_IDX);
  assert property (@(posedge clk) disable iff (!rst_n)
                   (nib_valid && $past(nib_valid)) |-> $stable(nib_out));

endmodule

// File: tb/tb_pcpi_result_tx.sv
// Scoreboard bench for pcpi_result_tx: a host model drives ack, a monitor
// compares every presented nibble and done pulse against a reference queue.
module tb_pcpi_result_tx;

  localparam int NIBBLES     = 8;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 1;
  localparam int TIMEOUT     = 200;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 res_valid = 1'b0;
  logic [4*NIBBLES-1:0] res_data = '0;
  logic                 res_ready;
  logic                 ack = 1'b0;
  logic [3:0]           nib_out;
  logic                 nib_valid;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;

  // Expected host-visible events in order: {0,nibble} or 5'h10 for done.
  logic [4:0] exp_q[$];

  logic       prev_valid = 1'b0;
  logic       prev_done  = 1'b0;
  logic [3:0] prev_nib   = 4'h0;

  pcpi_result_tx #(
    .NIBBLES    (NIBBLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_ready(res_ready),
    .ack      (ack),
    .nib_out  (nib_out),
    .nib_valid(nib_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic popCompare(input string name, input logic [4:0] got);
    logic [4:0] want;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got 0x%0h but nothing was expected", name, got);
    end else begin
      want = exp_q.pop_front();
      checkOutput(name, {27'b0, got}, {27'b0, want});
    end
  endtask

  // Reference model: nibble k of the word is (word / 16^k) mod 16, then done.
  task automatic pushWord(input logic [4*NIBBLES-1:0] w);
    logic [31:0] v;
    for (int k = 0; k < NIBBLES; k++) begin
      v = (32'(w) >> (4 * k)) % 16;
      exp_q.push_back({1'b0, v[3:0]});
    end
    exp_q.push_back(5'h10);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (nib_valid && !prev_valid) popCompare("nibble", {1'b0, nib_out});
      if (nib_valid && prev_valid) checkOutput("nib_out_stable", {28'b0, nib_out}, {28'b0, prev_nib});
      if (done) begin
        popCompare("done_event", 5'h10);
        checkOutput("done_single_cycle", {31'b0, prev_done}, 32'd0);
      end
    end
    prev_valid = nib_valid;
    prev_done  = done;
    prev_nib   = nib_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit sigIs(input int which);
    case (which)
      0:       return !nib_valid;
      1:       return nib_valid;
      default: return done;
    endcase
  endfunction

  task automatic waitSignal(input string name, input int which, output int edges);
    edges = 0;
    while (!sigIs(which) && edges < TIMEOUT) begin
      tick();
      edges++;
    end
    if (!sigIs(which)) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_%s: waited %0d edges without the event", name, edges);
      edges = -1;
    end
  endtask

  task automatic applyStimulus(input logic [4*NIBBLES-1:0] w);
    int e = 0;
    res_data  = w;
    res_valid = 1'b1;
    while (!res_ready && e < TIMEOUT) begin
      tick();
      e++;
    end
    if (!res_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_res_ready: got 0 after %0d edges, expected 1", e);
    end
    pushWord(w);
    tick();
    res_valid = 1'b0;
    checkOutput("load_busy", {31'b0, busy}, 32'd1);
    checkOutput("load_res_ready", {31'b0, res_ready}, 32'd0);
  endtask

  // Host side of one nibble; check_tail measures ack-fall to next event.
  task automatic ackNibble(input int hold, input int gap, input bit last, input bit check_tail);
    int e;
    waitSignal("nib_valid_rise", 1, e);
    repeat (hold) tick();
    ack = 1'b1;
    waitSignal("nib_valid_fall", 0, e);
    checkOutput("ack_rise_latency", e, LAT);
    repeat (gap) tick();
    ack = 1'b0;
    if (check_tail) begin
      if (last) begin
        waitSignal("done", 2, e);
        checkOutput("ack_fall_to_done", e, LAT);
        checkOutput("done_res_ready", {31'b0, res_ready}, 32'd1);
        checkOutput("done_busy", {31'b0, busy}, 32'd0);
      end else begin
        waitSignal("next_nib_valid", 1, e);
        checkOutput("ack_fall_latency", e, LAT);
      end
    end
  endtask

  task automatic sendWord(input logic [4*NIBBLES-1:0] w, input int max_hold, input int max_gap);
    applyStimulus(w);
    for (int k = 0; k < NIBBLES; k++) begin
      ackNibble(int'($urandom_range(max_hold, 0)), int'($urandom_range(max_gap, 0)),
                k == NIBBLES - 1, 1'b1);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_res_ready"}, {31'b0, res_ready}, 32'd0);
    checkOutput({tag, "_nib_valid"}, {31'b0, nib_valid}, 32'd0);
    checkOutput({tag, "_nib_out"}, {28'b0, nib_out}, 32'd0);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int e;
    logic [4*NIBBLES-1:0] w;

    // Power-on reset and release.
    repeat (2) tick();
    checkResetOutputs("por");
    rst_n = 1'b1;
    checkOutput("release_res_ready_before_edge", {31'b0, res_ready}, 32'd0);
    tick();
    checkOutput("release_res_ready", {31'b0, res_ready}, 32'd1);
    checkOutput("release_busy", {31'b0, busy}, 32'd0);

    $display("[TB] basic word 0x87654321");
    applyStimulus(32'h8765_4321);
    for (int k = 0; k < NIBBLES; k++) ackNibble(1, 1, k == NIBBLES - 1, 1'b1);

    $display("[TB] ack raised three cycles after nib_valid");
    applyStimulus(32'h0F1E_2D3C);
    for (int k = 0; k < NIBBLES; k++) ackNibble(3, 2, k == NIBBLES - 1, 1'b1);

    $display("[TB] stale ack high at load");
    tick();
    ack = 1'b1;
    repeat (3) tick();
    applyStimulus(32'hCAFE_BABE);
    repeat (5) begin
      tick();
      checkOutput("arm_nib_valid", {31'b0, nib_valid}, 32'd0);
      checkOutput("arm_busy", {31'b0, busy}, 32'd1);
    end
    ack = 1'b0;
    waitSignal("arm_release", 1, e);
    checkOutput("arm_release_latency", e, LAT);
    for (int k = 0; k < NIBBLES; k++) ackNibble(0, 0, k == NIBBLES - 1, 1'b1);

    $display("[TB] res_valid pulse during transfer is ignored");
    applyStimulus(32'h1357_9BDF);
    for (int k = 0; k < 2; k++) ackNibble(1, 1, 1'b0, 1'b1);
    res_data  = 32'hFFFF_FFFF;
    res_valid = 1'b1;
    repeat (3) begin
      tick();
      checkOutput("busy_res_ready", {31'b0, res_ready}, 32'd0);
    end
    res_valid = 1'b0;
    for (int k = 2; k < NIBBLES; k++) ackNibble(1, 1, k == NIBBLES - 1, 1'b1);

    $display("[TB] reset in the middle of a word");
    applyStimulus(32'h2468_ACE0);
    for (int k = 0; k < 4; k++) ackNibble(1, 1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    exp_q.delete();
    ack = 1'b0;
    repeat (2) tick();
    checkResetOutputs("held_reset");
    rst_n = 1'b1;
    tick();
    checkOutput("rerelease_res_ready", {31'b0, res_ready}, 32'd1);
    applyStimulus(32'h0000_00A5);
    for (int k = 0; k < NIBBLES; k++) ackNibble(1, 0, k == NIBBLES - 1, 1'b1);

    $display("[TB] back-to-back load in the done cycle");
    applyStimulus(32'h9ABC_DEF0);
    for (int k = 0; k < NIBBLES - 1; k++) ackNibble(0, 1, 1'b0, 1'b1);
    ackNibble(1, 1, 1'b1, 1'b0);
    res_data  = 32'h1111_1111;
    res_valid = 1'b1;
    waitSignal("chained_done", 2, e);
    checkOutput("chained_done_latency", e, LAT);
    checkOutput("chained_done_res_ready", {31'b0, res_ready}, 32'd1);
    pushWord(32'h1111_1111);
    tick();
    res_valid = 1'b0;
    checkOutput("chained_load_busy", {31'b0, busy}, 32'd1);
    checkOutput("chained_load_res_ready", {31'b0, res_ready}, 32'd0);
    for (int k = 0; k < NIBBLES; k++) ackNibble(1, 1, k == NIBBLES - 1, 1'b1);

    $display("[TB] randomized words");
    for (int n = 0; n < 8; n++) begin
      w = $urandom;
      repeat ($urandom_range(3, 0)) tick();
      sendWord(w, 4, 4);
    end

    repeat (10) tick();
    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
